// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter control path.
package bin2bcd_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    localparam logic [3:0] CORR_THRESH = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/add3.sv
// Per-digit double-dabble correction: digits at or above the threshold get +3 (mod 16).
module add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] corr_o,
    output logic       need_o
);

    assign need_o = (digit_i >= CORR_THRESH);
    // Illegal digits 10..15 simply wrap; the carry out is intentionally dropped.
    assign corr_o = need_o ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_ctrl.sv
// Sequencer for the shift-add-3 BCD converter: drives load/shift/correct controls
// of the downstream negedge shift register and captures the final digit field.
module bin2bcd_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   digits_in,
    output logic                  rst_ld,
    output logic                  shift,
    output logic [DIGITS-1:0]     lda2,
    output logic [4*DIGITS-1:0]   corr_out,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   need;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        add3 u_add3 (
            .digit_i (digits_in[4*i +: 4]),
            .corr_o  (corr_out[4*i +: 4]),
            .need_o  (need[i])
        );
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; reset is asynchronous and clears the result register too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        rst_ld  = 1'b0;
        shift   = 1'b0;
        lda2    = '0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                rst_ld  = 1'b1;
                cnt_d   = '0;
                state_d = CHECK;
            end
            CHECK: begin
                lda2    = need;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                // The last shift exits without incrementing, so the counter never wraps.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = CHECK;
                end
            end
            DONE: begin
                done    = 1'b1;
                bcd_d   = digits_in;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Directed bench for bin2bcd_ctrl with a behavioural negedge shift-register model downstream.
module tb_bin2bcd_ctrl;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] digits_in;
    logic        rst_ld;
    logic        shift;
    logic [4:0]  lda2;
    logic [19:0] corr_out;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;

    logic [35:0] sr = '0;
    logic [15:0] operand = '0;
    logic        force_en = 1'b0;
    logic [19:0] force_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .digits_in (digits_in),
        .rst_ld    (rst_ld),
        .shift     (shift),
        .lda2      (lda2),
        .corr_out  (corr_out),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out)
    );

    assign digits_in = force_en ? force_val : sr[35:16];

    // Downstream register model: load, shift, or per-digit corrected load on negedge.
    always @(negedge clk) begin
        if (rst_ld) begin
            sr <= {20'h0, operand};
        end else if (shift) begin
            sr <= sr << 1;
        end else begin
            for (int i = 0; i < DIGITS; i++)
                if (lda2[i]) sr[16+4*i +: 4] <= corr_out[4*i +: 4];
        end
    end

    function automatic logic [4:0] ge5(input logic [19:0] d);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = (d[4*i +: 4] >= 4'd5);
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion, gathering observations per cycle; cycle 1 is the LOAD cycle.
    task automatic convert(input logic [15:0] op, input bit repulse,
                           output int done_cyc, output int done_cnt, output int busy_fall,
                           output int seq_bad, output int lda2_bad, output logic [4:0] lda2_any);
        done_cyc = -1; done_cnt = 0; busy_fall = -1; seq_bad = 0; lda2_bad = 0; lda2_any = '0;
        operand = op;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            logic e_ld, e_sh, e_ck, e_busy, e_done;
            logic [4:0] e_lda2;
            e_ld   = (c == 1);
            e_ck   = (c >= 2 && c <= 32 && (c % 2) == 0);
            e_sh   = (c >= 3 && c <= 33 && (c % 2) == 1);
            e_busy = (c <= 34);
            e_done = (c == 34);
            e_lda2 = e_ck ? ge5(sr[35:16]) : 5'b0;
            if (rst_ld !== e_ld || shift !== e_sh || busy !== e_busy || done !== e_done) begin
                seq_bad++;
                $display("  cycle %0d: rst_ld=%b shift=%b busy=%b done=%b exp %b %b %b %b",
                         c, rst_ld, shift, busy, done, e_ld, e_sh, e_busy, e_done);
            end
            if (lda2 !== e_lda2) lda2_bad++;
            lda2_any |= lda2;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy === 1'b0 && busy_fall < 0) busy_fall = c;
            if (repulse) begin
                if (c == 5 || c == 20) start = 1'b1;
                else start = 1'b0;
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string name, input logic [19:0] exp_bcd,
                             input int done_cyc, input int done_cnt, input int busy_fall,
                             input int seq_bad, input int lda2_bad);
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL %s done_cycle got %0d exp 34", name, done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", name, done_cnt); end
        checks++; if (busy_fall !== 35) begin errors++; $display("FAIL %s busy_fall got %0d exp 35", name, busy_fall); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL %s control_seq bad_cycles got %0d exp 0", name, seq_bad); end
        checks++; if (lda2_bad !== 0) begin errors++; $display("FAIL %s lda2 bad_cycles got %0d exp 0", name, lda2_bad); end
        checks++; if (bcd_out !== exp_bcd) begin errors++; $display("FAIL %s bcd_out got %h exp %h", name, bcd_out, exp_bcd); end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rst_ld, shift, lda2, busy, done, bcd_out, corr_out} !== '0) begin
            errors++; $display("FAIL reset_in_reset got %h exp 0", {rst_ld, shift, lda2, busy, done, bcd_out, corr_out});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rst_ld, shift, lda2, busy, done, bcd_out, corr_out} !== '0) begin
                errors++; $display("FAIL reset_idle cycle %0d got %h exp 0", c, {rst_ld, shift, lda2, busy, done, bcd_out, corr_out});
            end
            next_cycle();
        end
    endtask

    task automatic test_correction();
        logic [19:0] vin [3];
        logic [19:0] vexp [3];
        vin[0] = 20'hFA950; vexp[0] = 20'h2DC80;
        vin[1] = 20'h43210; vexp[1] = 20'h43210;
        vin[2] = 20'hB6C7E; vexp[2] = 20'hE9FA1;
        force_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            force_val = vin[i];
            #1;
            checks++;
            if (corr_out !== vexp[i]) begin
                errors++; $display("FAIL corr_out vec %0d got %h exp %h", i, corr_out, vexp[i]);
            end
            checks++;
            if (lda2 !== 5'b0) begin
                errors++; $display("FAIL idle_lda2 vec %0d got %b exp 00000", i, lda2);
            end
        end
        force_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_max();
        int dc, dn, bf, sb, lb; logic [4:0] la;
        convert(16'd65535, 1'b0, dc, dn, bf, sb, lb, la);
        check_run("max_65535", 20'h65535, dc, dn, bf, sb, lb);
    endtask

    task automatic test_zero();
        int dc, dn, bf, sb, lb; logic [4:0] la;
        convert(16'd0, 1'b0, dc, dn, bf, sb, lb, la);
        check_run("zero", 20'h00000, dc, dn, bf, sb, lb);
        checks++;
        if (la !== 5'b0) begin errors++; $display("FAIL zero_lda2_any got %b exp 00000", la); end
    endtask

    task automatic test_9999();
        int dc, dn, bf, sb, lb; logic [4:0] la;
        convert(16'd9999, 1'b0, dc, dn, bf, sb, lb, la);
        check_run("op_9999", 20'h09999, dc, dn, bf, sb, lb);
        checks++;
        if (la === 5'b0) begin errors++; $display("FAIL op_9999_lda2_any got %b exp nonzero", la); end
    endtask

    task automatic test_start_ignored();
        int dc, dn, bf, sb, lb; logic [4:0] la;
        convert(16'd1234, 1'b1, dc, dn, bf, sb, lb, la);
        check_run("restart_ignored_1234", 20'h01234, dc, dn, bf, sb, lb);
    endtask

    task automatic test_reset_midrun();
        int dc, dn, bf, sb, lb; logic [4:0] la;
        operand = 16'd65535;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 15; c++) next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rst_ld, shift, lda2, busy, done, bcd_out} !== '0) begin
            errors++; $display("FAIL midrun_reset_async got %h exp 0", {rst_ld, shift, lda2, busy, done, bcd_out});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rst_ld, shift, lda2, busy, done, bcd_out} !== '0) begin
            errors++; $display("FAIL midrun_reset_held got %h exp 0", {rst_ld, shift, lda2, busy, done, bcd_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        checks++;
        if ({busy, bcd_out} !== '0) begin
            errors++; $display("FAIL midrun_post_reset got %h exp 0", {busy, bcd_out});
        end
        convert(16'd42, 1'b0, dc, dn, bf, sb, lb, la);
        check_run("restart_42", 20'h00042, dc, dn, bf, sb, lb);
    endtask

    initial begin
        test_reset();
        test_correction();
        test_max();
        test_zero();
        test_9999();
        test_start_ignored();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
